// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings, the responder state type and the burst
// next-address helper used by the simulation memory responder and the
// burst tracker.
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } resp_state_t;

    // Only 4-beat bursts are tracked; every other encoding behaves as SINGLE.
    function automatic logic is_tracked_burst(input hburst_t burst);
        return (burst == HBURST_WRAP4) || (burst == HBURST_INCR4);
    endfunction

    // WRAP4 wraps inside the 16-byte line; INCR4 simply steps one word.
    function automatic logic [31:0] burst_next_addr(input logic [31:0] addr,
                                                    input hburst_t     burst);
        logic [1:0] w_word_sel;
        w_word_sel = addr[3:2] + 2'd1;
        if (burst == HBURST_WRAP4) begin
            return {addr[31:4], w_word_sel, 2'b00};
        end
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// ---------------------------------------------------------------------------
// ahb_burst_tracker
// Follows 4-beat AHB bursts on accepted transfers and flags SEQ beats that
// break the sequence (no burst open, wrong address, or changed HBURST).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_accept         transfer accepted this cycle (HSEL & HREADY & HTRANS[1])
//   i_htrans         HTRANS of the accepted transfer
//   i_hburst         HBURST of the accepted transfer
//   i_haddr          HADDR of the accepted transfer
//   o_err            single-cycle pulse: accepted SEQ beat is illegal
//   o_expected       address the next SEQ beat must carry
// ---------------------------------------------------------------------------
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_accept,
    input  logic [1:0]  i_htrans,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_haddr,
    output logic        o_err,
    output logic [31:0] o_expected
);

    logic        r_active;
    logic [2:0]  r_beats;
    logic [31:0] r_expected;
    hburst_t     r_burst;

    hburst_t     w_burst;
    logic        w_nonseq;
    logic        w_seq;
    logic        w_seq_err;
    logic [2:0]  w_beats_inc;

    assign w_burst     = hburst_t'(i_hburst);
    assign w_nonseq    = (htrans_t'(i_htrans) == HTRANS_NONSEQ);
    assign w_seq       = (htrans_t'(i_htrans) == HTRANS_SEQ);
    assign w_beats_inc = r_beats + 3'd1;

    assign w_seq_err = i_accept && w_seq &&
                       (!r_active || (i_haddr != r_expected) || (w_burst != r_burst));

    assign o_err      = w_seq_err;
    assign o_expected = r_expected;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active   <= 1'b0;
            r_beats    <= 3'd0;
            r_expected <= 32'd0;
            r_burst    <= HBURST_SINGLE;
        end else if (i_accept) begin
            if (w_nonseq) begin
                // A NONSEQ always restarts tracking, which also covers early
                // termination of a burst still in flight.
                r_burst    <= w_burst;
                r_expected <= burst_next_addr(i_haddr, w_burst);
                if (is_tracked_burst(w_burst)) begin
                    r_active <= 1'b1;
                    r_beats  <= 3'd1;
                end else begin
                    r_active <= 1'b0;
                    r_beats  <= 3'd0;
                end
            end else if (w_seq) begin
                if (w_seq_err) begin
                    // Drop the broken burst so one bad beat is not re-flagged
                    // against a stale expectation.
                    r_active <= 1'b0;
                    r_beats  <= 3'd0;
                end else begin
                    r_beats    <= w_beats_inc;
                    r_expected <= burst_next_addr(i_haddr, w_burst);
                    r_active   <= (w_beats_inc != 3'd4);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sim_mem_responder.sv
// ---------------------------------------------------------------------------
// ahb_sim_mem_responder
// Read-only AHB-Lite simulation memory. Each mapped word returns its own
// word index relative to BASE_ADDR, so a refilling cache can check every
// word against its address. Adds wait states, ERROR responses and a sticky
// burst-protocol flag.
//
// Ports:
//   HCLK, HRESETn    clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY   AHB-Lite inputs
//   HREADYOUT        low only while stalling (WAIT) or in the first ERROR cycle
//   HRESP            0 = OKAY, 1 = ERROR
//   HRDATA           word index in DATA, zero otherwise
//   protocol_err     sticky burst-sequence violation flag
//
// state | meaning
// IDLE  | no data phase pending, ready for an address phase
// WAIT  | read accepted, counting down wait states
// DATA  | read data on HRDATA; also the next address phase
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high; also the next address phase
// ---------------------------------------------------------------------------
module ahb_sim_mem_responder
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0a00,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIRST_WAIT = 2,
    parameter int          SEQ_WAIT   = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        protocol_err
);

    // 33-bit bounds so a map ending at the top of the address space does
    // not wrap the limit back to zero.
    localparam logic [32:0] ADDR_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI    = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
    localparam logic [31:0] BASE_WORD  = BASE_ADDR >> 2;
    localparam logic [7:0]  FIRST_W    = 8'(FIRST_WAIT);
    localparam logic [7:0]  SEQ_W      = 8'(SEQ_WAIT);

    resp_state_t r_state;
    resp_state_t w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_hrdata;
    logic        r_protocol_err;

    logic        w_hreadyout;
    logic        w_hresp;
    logic        w_addr_phase;
    logic        w_accept;
    logic        w_bad;
    logic [7:0]  w_wait_load;
    logic [31:0] w_data_addr;
    logic        w_trk_err;
    logic [31:0] w_trk_expected_unused;

    // Only states driving HREADYOUT high can see a real address phase.
    assign w_addr_phase = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                          (r_state == ST_ERR2);
    assign w_accept     = HSEL && HREADY && HTRANS[1] && w_addr_phase;

    assign w_bad = HWRITE ||
                   (HSIZE != HSIZE_WORD) ||
                   (HADDR[1:0] != 2'b00) ||
                   ({1'b0, HADDR} < ADDR_LO) ||
                   ({1'b0, HADDR} >= ADDR_HI);

    assign w_wait_load = (htrans_t'(HTRANS) == HTRANS_NONSEQ) ? FIRST_W : SEQ_W;

    // Data for a zero-wait beat comes from the address being captured now;
    // after a stall it comes from the captured address.
    assign w_data_addr = (r_state == ST_WAIT) ? r_addr : HADDR;

    ahb_burst_tracker u_tracker (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_accept   (w_accept),
        .i_htrans   (HTRANS),
        .i_hburst   (HBURST),
        .i_haddr    (HADDR),
        .o_err      (w_trk_err),
        .o_expected (w_trk_expected_unused)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!w_accept) begin
                    w_next_state = ST_IDLE;
                end else if (w_bad) begin
                    w_next_state = ST_ERR1;
                end else if (w_wait_load == 8'd0) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= 8'd1) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_ERR1: w_next_state = ST_ERR2;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        unique case (r_state)
            ST_WAIT: w_hreadyout = 1'b0;
            ST_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
            end
            ST_ERR2: w_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt     <= 8'd0;
            r_addr         <= 32'd0;
            r_hrdata       <= 32'd0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= HADDR;
            end

            if ((w_next_state == ST_WAIT) && (r_state != ST_WAIT)) begin
                r_wait_cnt <= w_wait_load;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end

            if (w_next_state == ST_DATA) begin
                r_hrdata <= (w_data_addr >> 2) - BASE_WORD;
            end else begin
                r_hrdata <= 32'd0;
            end

            if (w_trk_err) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign HREADYOUT    = w_hreadyout;
    assign HRESP        = w_hresp;
    assign HRDATA       = r_hrdata;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_ahb_sim_mem_responder.sv
module tb_ahb_sim_mem_responder;

    localparam logic [1:0] TI = 2'd0;
    localparam logic [1:0] TB = 2'd1;
    localparam logic [1:0] NS = 2'd2;
    localparam logic [1:0] SQ = 2'd3;
    localparam logic [2:0] SG = 3'd0;
    localparam logic [2:0] W4 = 3'd2;
    localparam logic [2:0] I4 = 3'd3;
    localparam logic [2:0] SZW = 3'd2;

    typedef struct {
        logic        dut;     // 0: FIRST_WAIT=2/SEQ_WAIT=0, 1: FIRST_WAIT=0/SEQ_WAIT=1
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic        exp_rdy;
        logic        exp_resp;
        logic [31:0] exp_data;
        logic        exp_perr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        rdy_a, resp_a, perr_a;
    logic        rdy_b, resp_b, perr_b;
    logic [31:0] data_a, data_b;

    vec_t tbl[$];
    int   n_checks;
    int   n_errors;
    int   split;

    ahb_sim_mem_responder u_dut_a (
        .HCLK         (clk),
        .HRESETn      (rst_n),
        .HSEL         (hsel_a),
        .HADDR        (haddr),
        .HTRANS       (htrans),
        .HWRITE       (hwrite),
        .HSIZE        (hsize),
        .HBURST       (hburst),
        .HREADY       (rdy_a),
        .HREADYOUT    (rdy_a),
        .HRESP        (resp_a),
        .HRDATA       (data_a),
        .protocol_err (perr_a)
    );

    ahb_sim_mem_responder #(.FIRST_WAIT(0), .SEQ_WAIT(1)) u_dut_b (
        .HCLK         (clk),
        .HRESETn      (rst_n),
        .HSEL         (hsel_b),
        .HADDR        (haddr),
        .HTRANS       (htrans),
        .HWRITE       (hwrite),
        .HSIZE        (hsize),
        .HBURST       (hburst),
        .HREADY       (rdy_b),
        .HREADYOUT    (rdy_b),
        .HRESP        (resp_b),
        .HRDATA       (data_b),
        .protocol_err (perr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic d, input logic s, input logic [1:0] t,
                                input logic [2:0] b, input logic [31:0] a,
                                input logic w, input logic [2:0] z,
                                input logic er, input logic ep,
                                input logic [31:0] ed, input logic epe);
        vec_t v;
        v.dut = d; v.sel = s; v.trans = t; v.burst = b; v.addr = a;
        v.wr = w; v.size = z; v.exp_rdy = er; v.exp_resp = ep;
        v.exp_data = ed; v.exp_perr = epe;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input logic d, input logic er, input logic ep,
                                 input logic [31:0] ed, input logic epe);
        add(d, 1'b0, TI, SG, 32'h0, 1'b0, SZW, er, ep, ed, epe);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic apply(input int i);
        vec_t v;
        v = tbl[i];
        @(posedge clk);
        #1;
        hsel_a = v.sel & ~v.dut;
        hsel_b = v.sel & v.dut;
        htrans = v.trans;
        hburst = v.burst;
        haddr  = v.addr;
        hwrite = v.wr;
        hsize  = v.size;
        @(negedge clk);
        if (v.dut) begin
            chk("hreadyout", i, {31'd0, rdy_b}, {31'd0, v.exp_rdy});
            chk("hresp", i, {31'd0, resp_b}, {31'd0, v.exp_resp});
            chk("hrdata", i, data_b, v.exp_data);
            chk("protocol_err", i, {31'd0, perr_b}, {31'd0, v.exp_perr});
        end else begin
            chk("hreadyout", i, {31'd0, rdy_a}, {31'd0, v.exp_rdy});
            chk("hresp", i, {31'd0, resp_a}, {31'd0, v.exp_resp});
            chk("hrdata", i, data_a, v.exp_data);
            chk("protocol_err", i, {31'd0, perr_a}, {31'd0, v.exp_perr});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        hsel_a = 1'b0; hsel_b = 1'b0;
        haddr  = 32'h0; htrans = TI; hburst = SG; hwrite = 1'b0; hsize = SZW;

        // SINGLE NONSEQ 0x0a10: two stall cycles, then word 4
        add(0, 1, NS, SG, 32'h0a10, 0, SZW, 1, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        idle(0, 1, 0, 4, 0);
        idle(0, 1, 0, 0, 0);
        // WRAP4 at 0x0a18: 6,7,4,5 back to back after the first-beat stall
        add(0, 1, NS, W4, 32'h0a18, 0, SZW, 1, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 0, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 0, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 1, 0, 6, 0);
        add(0, 1, SQ, W4, 32'h0a10, 0, SZW, 1, 0, 7, 0);
        add(0, 1, SQ, W4, 32'h0a14, 0, SZW, 1, 0, 4, 0);
        add(0, 1, TI, SG, 32'h0, 0, SZW, 1, 0, 5, 0);
        idle(0, 1, 0, 0, 0);
        // INCR4 at 0x0a00 on the zero-first-wait instance, one stall per SEQ
        add(1, 1, NS, I4, 32'h0a00, 0, SZW, 1, 0, 0, 0);
        add(1, 1, SQ, I4, 32'h0a04, 0, SZW, 1, 0, 0, 0);
        add(1, 1, SQ, I4, 32'h0a08, 0, SZW, 0, 0, 0, 0);
        add(1, 1, SQ, I4, 32'h0a08, 0, SZW, 1, 0, 1, 0);
        add(1, 1, SQ, I4, 32'h0a0c, 0, SZW, 0, 0, 0, 0);
        add(1, 1, SQ, I4, 32'h0a0c, 0, SZW, 1, 0, 2, 0);
        add(1, 1, TI, SG, 32'h0, 0, SZW, 0, 0, 0, 0);
        idle(1, 1, 0, 3, 0);
        idle(1, 1, 0, 0, 0);
        // SEQ with the right address but a changed HBURST
        add(1, 1, NS, I4, 32'h0a00, 0, SZW, 1, 0, 0, 0);
        add(1, 1, SQ, W4, 32'h0a04, 0, SZW, 1, 0, 0, 0);
        add(1, 1, TI, SG, 32'h0, 0, SZW, 0, 0, 0, 1);
        idle(1, 1, 0, 1, 1);
        idle(1, 1, 0, 0, 1);
        // ERROR responses: write, below base, top word ok, past top, halfword, misaligned
        add(0, 1, NS, SG, 32'h0a00, 1, SZW, 1, 0, 0, 0);
        idle(0, 0, 1, 0, 0);
        add(0, 1, NS, SG, 32'h09fc, 0, SZW, 1, 1, 0, 0);
        idle(0, 0, 1, 0, 0);
        idle(0, 1, 1, 0, 0);
        add(0, 1, NS, SG, 32'h19fc, 0, SZW, 1, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        add(0, 1, NS, SG, 32'h1a00, 0, SZW, 1, 0, 32'h3ff, 0);
        idle(0, 0, 1, 0, 0);
        add(0, 1, NS, SG, 32'h0a04, 0, 3'd1, 1, 1, 0, 0);
        idle(0, 0, 1, 0, 0);
        add(0, 1, NS, SG, 32'h0a06, 0, SZW, 1, 1, 0, 0);
        idle(0, 0, 1, 0, 0);
        idle(0, 1, 1, 0, 0);
        // BUSY, IDLE and unselected NONSEQ start no data phase
        add(0, 1, TB, SG, 32'h0a00, 0, SZW, 1, 0, 0, 0);
        add(0, 1, TI, SG, 32'h0a00, 0, SZW, 1, 0, 0, 0);
        add(0, 0, NS, SG, 32'h0a00, 0, SZW, 1, 0, 0, 0);
        idle(0, 1, 0, 0, 0);
        // WRAP4 then SEQ 0x0a20: sticky flag, survives a later legal burst
        add(0, 1, NS, W4, 32'h0a18, 0, SZW, 1, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a20, 0, SZW, 0, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a20, 0, SZW, 0, 0, 0, 0);
        add(0, 1, SQ, W4, 32'h0a20, 0, SZW, 1, 0, 6, 0);
        add(0, 1, TI, SG, 32'h0, 0, SZW, 1, 0, 8, 1);
        add(0, 1, NS, W4, 32'h0a18, 0, SZW, 1, 0, 0, 1);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 0, 0, 0, 1);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 0, 0, 0, 1);
        add(0, 1, SQ, W4, 32'h0a1c, 0, SZW, 1, 0, 6, 1);
        add(0, 1, SQ, W4, 32'h0a10, 0, SZW, 1, 0, 7, 1);
        add(0, 1, SQ, W4, 32'h0a14, 0, SZW, 1, 0, 4, 1);
        add(0, 1, TI, SG, 32'h0, 0, SZW, 1, 0, 5, 1);
        idle(0, 1, 0, 0, 1);
        split = tbl.size();
        // After a reset taken mid-WAIT: fresh read of 0x0a04 returns 1
        add(0, 1, NS, SG, 32'h0a04, 0, SZW, 1, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        idle(0, 1, 0, 1, 0);
        idle(0, 1, 0, 0, 0);

        #23;
        chk("reset hreadyout", -1, {31'd0, rdy_a}, 32'd1);
        chk("reset hresp", -1, {31'd0, resp_a}, 32'd0);
        chk("reset hrdata", -1, data_a, 32'd0);
        chk("reset protocol_err", -1, {31'd0, perr_a}, 32'd0);
        chk("reset hreadyout b", -1, {31'd0, rdy_b}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < split; i++) apply(i);

        // Reset asserted during the WAIT of a NONSEQ read
        @(posedge clk);
        #1;
        hsel_a = 1'b1; htrans = NS; hburst = SG; haddr = 32'h0a10; hwrite = 1'b0; hsize = SZW;
        @(posedge clk);
        #1;
        hsel_a = 1'b0; htrans = TI;
        @(negedge clk);
        chk("midwait hreadyout", -2, {31'd0, rdy_a}, 32'd0);
        chk("midwait protocol_err a", -2, {31'd0, perr_a}, 32'd1);
        chk("midwait protocol_err b", -2, {31'd0, perr_b}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async hreadyout", -3, {31'd0, rdy_a}, 32'd1);
        chk("async hresp", -3, {31'd0, resp_a}, 32'd0);
        chk("async hrdata", -3, data_a, 32'd0);
        chk("async protocol_err a", -3, {31'd0, perr_a}, 32'd0);
        chk("async protocol_err b", -3, {31'd0, perr_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = split; i < tbl.size(); i++) apply(i);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
